jpeg_pipe_sequencer: RTL and testbench

Parametrised frame sequencer for the JPEG row pipeline: on a start request it drives the input-memory read address, the ping-pong select lines for the DCT transpose and zig-zag buffers, the quantiser row index, the output-memory write address and the RLE enable from a single frame tick counter. It replaces the fixed free-running counters with a start/done handshake, programmable frame length, pipeline stall and configurable stage offsets. It sits at the top level beside the memories and datapath stages, which it controls without touching data.

---
 rtl/jpeg_seq_pkg.sv | 18 +
 rtl/jpeg_seq_phase.sv | 21 ++
 rtl/jpeg_pipe_sequencer.sv | 166 ++++++++++++++++
 tb/tb_jpeg_pipe_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/jpeg_seq_pkg.sv
// Shared types and default timing constants for the JPEG row-pipeline sequencer.
package jpeg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_BLK_LOG2 = 3;
  localparam int DEF_OUT_LAT  = 20;
  localparam int DEF_RLE_LAT  = 19;
  localparam int DEF_TP2_OFS  = 10;
  localparam int DEF_QT_OFS   = 3;

endpackage

// File: rtl/jpeg_seq_phase.sv
// Block-phase decoder: from the low tick bits and a fixed stage offset,
// produce the ping-pong bank select and the row index within the block.
// Only the low BLK_LOG2+1 tick bits matter because the subtraction wraps.
module jpeg_seq_phase #(
  parameter int BLK_LOG2 = 3,
  parameter int OFS      = 0
) (
  input  logic [BLK_LOG2:0]   tick,
  output logic                sel,
  output logic [BLK_LOG2-1:0] row
);

  localparam logic [BLK_LOG2:0] OFS_L = (BLK_LOG2+1)'(OFS);

  logic [BLK_LOG2:0] phase;

  assign phase = tick - OFS_L;
  assign sel   = ~phase[BLK_LOG2];
  assign row   = phase[BLK_LOG2-1:0];

endmodule

// File: rtl/jpeg_pipe_sequencer.sv
// Frame sequencer for the JPEG row pipeline. A single tick counter, advanced
// once per unstalled cycle, drives every memory address and stage select.
// Optional build macro JPEG_SEQ_CHECK_EN: reject illegal frame lengths and
// flag them on err; without it, frame lengths are rounded down to whole
// blocks and clamped to the memory depth.
module jpeg_pipe_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BLK_LOG2 = DEF_BLK_LOG2,
  parameter int OUT_LAT  = DEF_OUT_LAT,
  parameter int RLE_LAT  = DEF_RLE_LAT,
  parameter int TP2_OFS  = DEF_TP2_OFS,
  parameter int QT_OFS   = DEF_QT_OFS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     frame_rows,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                tp1_sel,
  output logic                tp2_sel,
  output logic [BLK_LOG2-1:0] row_idx,
  output logic                rle_en
);

  localparam int TICK_W = ADDR_W + 2;
  localparam int N_W    = ADDR_W + 1;
  localparam logic [N_W-1:0]    MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TICK_W-1:0] OUT_LAT_T = TICK_W'(OUT_LAT);
  localparam logic [TICK_W-1:0] RLE_LAT_T = TICK_W'(RLE_LAT);

  seq_state_t          state, state_nx;
  logic [TICK_W-1:0]   tick, tick_nx;
  logic [N_W-1:0]      n_rows, n_rows_nx;
  logic [N_W-1:0]      rows_eff;
  logic                rows_ok;
  logic [TICK_W-1:0]   last_rd_tick;
  logic [TICK_W-1:0]   last_wr_tick;
  logic                active;
  logic                wr_win;

  logic                tp1_raw, tp2_raw;
  logic [BLK_LOG2-1:0] row_raw;
  logic [BLK_LOG2-1:0] unused_tp1_row;
  logic [BLK_LOG2-1:0] unused_tp2_row;
  logic                unused_qt_sel;

`ifdef JPEG_SEQ_CHECK_EN
  function automatic logic rows_legal(input logic [N_W-1:0] r);
    return (r[BLK_LOG2-1:0] == '0) && (r <= MAX_ROWS);
  endfunction

  logic err_q;
  logic err_set;

  assign rows_ok  = rows_legal(frame_rows);
  assign rows_eff = frame_rows;
  assign err_set  = (state == IDLE) && start && !rows_ok;

  // Sticky error flag for rejected start requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  function automatic logic [N_W-1:0] clamp_rows(input logic [N_W-1:0] r);
    if (r > MAX_ROWS) return MAX_ROWS;
    return {r[N_W-1:BLK_LOG2], {BLK_LOG2{1'b0}}};
  endfunction

  assign rows_ok  = 1'b1;
  assign rows_eff = clamp_rows(frame_rows);
  assign err      = 1'b0;
`endif

  assign last_rd_tick = TICK_W'(n_rows) - 1'b1;
  assign last_wr_tick = TICK_W'(n_rows) + OUT_LAT_T - 1'b1;

  // Control state register; everything visible outside decodes from these.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tick   <= '0;
      n_rows <= '0;
    end else begin
      state  <= state_nx;
      tick   <= tick_nx;
      n_rows <= n_rows_nx;
    end
  end

  // Next-state logic: accept start in IDLE, advance tick on unstalled cycles.
  always_comb begin
    state_nx  = state;
    tick_nx   = tick;
    n_rows_nx = n_rows;
    case (state)
      IDLE: begin
        if (start && rows_ok) begin
          n_rows_nx = rows_eff;
          tick_nx   = '0;
          state_nx  = (rows_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          tick_nx = tick + 1'b1;
          if (tick == last_rd_tick) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!stall) begin
          tick_nx = tick + 1'b1;
          if (tick == last_wr_tick) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign active  = (state == RUN) || (state == DRAIN);
  assign wr_win  = active && (tick >= OUT_LAT_T);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rd_en   = (state == RUN) && !stall;
  assign rd_addr = tick[ADDR_W-1:0];
  assign wr_en   = wr_win && !stall;
  assign wr_addr = wr_win ? (tick[ADDR_W-1:0] - ADDR_W'(OUT_LAT)) : '0;
  assign rle_en  = active && (tick >= RLE_LAT_T);

  jpeg_seq_phase #(.BLK_LOG2(BLK_LOG2), .OFS(0)) u_tp1 (
    .tick (tick[BLK_LOG2:0]),
    .sel  (tp1_raw),
    .row  (unused_tp1_row)
  );

  jpeg_seq_phase #(.BLK_LOG2(BLK_LOG2), .OFS(TP2_OFS)) u_tp2 (
    .tick (tick[BLK_LOG2:0]),
    .sel  (tp2_raw),
    .row  (unused_tp2_row)
  );

  jpeg_seq_phase #(.BLK_LOG2(BLK_LOG2), .OFS(QT_OFS)) u_qt (
    .tick (tick[BLK_LOG2:0]),
    .sel  (unused_qt_sel),
    .row  (row_raw)
  );

  // Selects rest at their idle values outside an active frame.
  assign tp1_sel = active ? tp1_raw : 1'b1;
  assign tp2_sel = active ? tp2_raw : 1'b1;
  assign row_idx = active ? row_raw : '0;

endmodule

// File: tb/tb_jpeg_pipe_sequencer.sv
// Directed bench for jpeg_pipe_sequencer with default parameters.
module tb_jpeg_pipe_sequencer;

  localparam int ADDR_W   = 15;
  localparam int BLK_LOG2 = 3;
  localparam int OUT_LAT  = 20;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W:0]     frame_rows = '0;
  logic                stall = 1'b0;
  logic                busy, done, err, rd_en, wr_en, tp1_sel, tp2_sel, rle_en;
  logic [ADDR_W-1:0]   rd_addr, wr_addr;
  logic [BLK_LOG2-1:0] row_idx;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] tp1_mask = 24'hFF00FF;
  logic [23:0] tp2_mask = 24'h03FC03;

  jpeg_pipe_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_rows (frame_rows),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .tp1_sel    (tp1_sel),
    .tp2_sel    (tp2_sel),
    .row_idx    (row_idx),
    .rle_en     (rle_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"},    busy,    0);
    chk({nm, " done"},    done,    0);
    chk({nm, " err"},     err,     0);
    chk({nm, " rd_en"},   rd_en,   0);
    chk({nm, " wr_en"},   wr_en,   0);
    chk({nm, " rd_addr"}, rd_addr, 0);
    chk({nm, " wr_addr"}, wr_addr, 0);
    chk({nm, " tp1_sel"}, tp1_sel, 1);
    chk({nm, " tp2_sel"}, tp2_sel, 1);
    chk({nm, " row_idx"}, row_idx, 0);
    chk({nm, " rle_en"},  rle_en,  0);
  endtask

  // Runs one frame starting at the next edge; et is the bench's own tick.
  task automatic run_frame(input string nm, input int n, input int exp_n,
                           input int stall_at, input int stall_len,
                           input int start_at, input int reset_at,
                           input bit phase_chk);
    int et, rd_exp, wr_exp, n_rd, n_wr, n_done, n_busy, done_idx;
    int first_wr, last_wr, stall_left, exp_busy;
    bit stall_now, ended, start_sent, aborted;
    et = 0; rd_exp = 0; wr_exp = 0; n_rd = 0; n_wr = 0; n_done = 0;
    n_busy = 0; done_idx = -1; first_wr = -1; last_wr = -1;
    stall_left = stall_len; ended = 0; start_sent = 0; aborted = 0;
    exp_busy = (exp_n == 0) ? 1 : exp_n + OUT_LAT + 1 + stall_len;

    @(posedge clk); #1;
    start = 1'b1; frame_rows = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0; frame_rows = '0;

    for (int c = 0; c < 400 && !ended; c++) begin
      stall_now = (stall_left > 0) && (et == stall_at);
      if (stall_now) stall_left--;
      stall = stall_now;
      if (start_at >= 0 && et == start_at && !start_sent) begin
        start = 1'b1; frame_rows = 8; start_sent = 1;
      end else begin
        start = 1'b0; frame_rows = '0;
      end
      @(negedge clk);
      if (!busy) begin
        ended = 1;
      end else begin
        n_busy++;
        if (rd_en) begin
          chk({nm, " rd_addr"}, rd_addr, rd_exp);
          rd_exp++; n_rd++;
        end
        if (wr_en) begin
          if (first_wr < 0) first_wr = et;
          last_wr = et;
          chk({nm, " wr_addr"}, wr_addr, wr_exp);
          wr_exp++; n_wr++;
        end
        if (stall_now) begin
          chk({nm, " stall rd_en"}, rd_en, 0);
          chk({nm, " stall wr_en"}, wr_en, 0);
        end
        if (done) begin
          n_done++; done_idx = c;
        end
        if (phase_chk && et < 24) begin
          chk({nm, " tp1_sel"}, tp1_sel, tp1_mask[et]);
          chk({nm, " tp2_sel"}, tp2_sel, tp2_mask[et]);
          chk({nm, " row_idx"}, row_idx, (et + 5) % 8);
          chk({nm, " rle_en"},  rle_en,  (et >= 19) ? 1 : 0);
        end
        if (reset_at >= 0 && et == reset_at) begin
          #1 reset = 1'b0;
          #1 chk_idle({nm, " mid-reset"});
          #1 reset = 1'b1;
          ended = 1; aborted = 1;
        end
        if (!ended) begin
          @(posedge clk); #1;
          if (!stall_now && et < exp_n + OUT_LAT) et++;
        end
      end
    end
    stall = 1'b0; start = 1'b0; frame_rows = '0;

    if (!ended) chk({nm, " timeout"}, 1, 0);
    if (!aborted) begin
      chk({nm, " busy cycles"}, n_busy, exp_busy);
      chk({nm, " done index"},  done_idx, exp_busy - 1);
      chk({nm, " done count"},  n_done, 1);
      chk({nm, " reads"},       n_rd, exp_n);
      chk({nm, " writes"},      n_wr, exp_n);
      chk({nm, " err"},         err, 0);
      if (exp_n > 0) begin
        chk({nm, " first wr tick"}, first_wr, OUT_LAT);
        chk({nm, " last wr tick"},  last_wr,  exp_n + OUT_LAT - 1);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    #2 reset = 1'b1;
    @(negedge clk);
    chk_idle("idle after reset");

    run_frame("f16",       16, 16, -1, 0, -1, -1, 1'b1);
    run_frame("f16 stall", 16, 16,  7, 3, -1, -1, 1'b0);
    run_frame("f16 start", 16, 16, -1, 0, 25, -1, 1'b0);
    run_frame("f0",         0,  0, -1, 0, -1, -1, 1'b0);
    run_frame("f16 rst",   16, 16, -1, 0, -1,  5, 1'b0);
    @(negedge clk);
    chk_idle("after mid reset");
    run_frame("f8",         8,  8, -1, 0, -1, -1, 1'b0);

`ifdef JPEG_SEQ_CHECK_EN
    @(posedge clk); #1;
    start = 1'b1; frame_rows = 12;
    @(posedge clk); #1;
    start = 1'b0; frame_rows = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("f12 busy", busy, 0);
      chk("f12 rd_en", rd_en, 0);
    end
    chk("f12 err", err, 1);
`else
    run_frame("f12",       12,  8, -1, 0, -1, -1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
